// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- raster timing generator for a VGA-style display.
//
// Produces the pixel column / line counters and the sync, display-enable and
// line/frame start strobes for a configurable video mode. Every output is a
// register; sync and display-enable are decoded from the counter values about
// to be loaded, so they carry no skew relative to the counter outputs.
//
// Parameters
//   H_ACTIVE/H_FP/H_SYNC/H_BP  horizontal active, front porch, sync, back porch
//   V_ACTIVE/V_FP/V_SYNC/V_BP  vertical equivalents, in lines
//   HS_POL/VS_POL              asserted sync level (0 = active-low)
//   CNT_W                      counter width; both totals must fit in 2^CNT_W
//
// Ports
//   PixClk      in   pixel clock, all state on its rising edge
//   Locked      in   asynchronous active-low reset (e.g. PLL lock)
//   PixEn       in   pixel clock-enable; state advances only when high
//   Hcounter    out  current pixel column, 0..H_TOTAL-1
//   Vcounter    out  current line, 0..V_TOTAL-1
//   Hsync       out  horizontal sync, HS_POL while asserted
//   Vsync       out  vertical sync, VS_POL while asserted
//   DispEn      out  high inside the active area
//   LineStart   out  one-cycle pulse after Hcounter is loaded with 0
//   FrameStart  out  one-cycle pulse after (Hcounter,Vcounter) is loaded with (0,0)

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             PixClk,
  input  logic             Locked,
  input  logic             PixEn,
  output logic [CNT_W-1:0] Hcounter,
  output logic [CNT_W-1:0] Vcounter,
  output logic             Hsync,
  output logic             Vsync,
  output logic             DispEn,
  output logic             LineStart,
  output logic             FrameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Sync level for a counter value: asserted level inside [first, last].
  // A zero-width sync (last < first) never asserts.
  function automatic logic sync_level(input logic [CNT_W-1:0] cnt,
                                      input logic [CNT_W-1:0] first,
                                      input logic [CNT_W-1:0] last,
                                      input logic             pol);
    return ((cnt >= first) && (cnt <= last)) ? pol : ~pol;
  endfunction

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;

  // ---- stage 0: next raster position, assuming this edge is enabled ----
  always_comb begin
    h_wrap = (Hcounter == H_LAST);
    v_wrap = (Vcounter == V_LAST);
    h_nxt  = h_wrap ? '0 : Hcounter + 1'b1;
    v_nxt  = Vcounter;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : Vcounter + 1'b1;
    end
  end

  // ---- stage 1: counters and their decodes registered together ----
  // Reset parks the raster on its last position so the first enabled edge
  // lands on (0,0) and the first frame is complete.
  always_ff @(posedge PixClk or negedge Locked) begin
    if (!Locked) begin
      Hcounter   <= H_LAST;
      Vcounter   <= V_LAST;
      Hsync      <= ~HS_POL;
      Vsync      <= ~VS_POL;
      DispEn     <= 1'b0;
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      // Strobes are rewritten every edge, so they drop after one PixClk
      // cycle even when the following edge is not enabled.
      LineStart  <= PixEn && h_wrap;
      FrameStart <= PixEn && h_wrap && v_wrap;
      if (PixEn) begin
        Hcounter <= h_nxt;
        Vcounter <= v_nxt;
        Hsync    <= sync_level(h_nxt, HS_FIRST, HS_LAST, HS_POL);
        Vsync    <= sync_level(v_nxt, VS_FIRST, VS_LAST, VS_POL);
        DispEn   <= (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
      end
    end
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front-porch pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync-pulse pixels.
REQ-004 Parameter H_BP, default 48, horizontal back-porch pixels.
REQ-005 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical equivalents in lines.
REQ-006 Parameters HS_POL and VS_POL, default 0 each, asserted sync level (0 = active-low).
REQ-007 Parameter CNT_W, default 10, counter width; H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL (same sum) SHALL each be <= 2^CNT_W.
REQ-008 PixClk  input  1  pixel clock; all state on its rising edge.
REQ-009 Locked  input  1  asynchronous active-low reset.
REQ-010 PixEn  input  1  pixel clock-enable; state advances only on edges with PixEn=1.
REQ-011 Hcounter  output  CNT_W  current pixel column, 0..H_TOTAL-1.
REQ-012 Vcounter  output  CNT_W  current line, 0..V_TOTAL-1.
REQ-013 Hsync  output  1  horizontal sync at HS_POL level while asserted.
REQ-014 Vsync  output  1  vertical sync at VS_POL level while asserted.
REQ-015 DispEn  output  1  high when (Hcounter,Vcounter) is inside the active area.
REQ-016 LineStart  output  1  one-clock pulse when Hcounter becomes 0.
REQ-017 FrameStart  output  1  one-clock pulse when (Hcounter,Vcounter) becomes (0,0).

Function
REQ-018 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-019 On an enabled edge Hcounter SHALL increment by 1, wrapping H_TOTAL-1 -> 0.
REQ-020 Vcounter SHALL increment only on the enabled edge where Hcounter wraps, wrapping V_TOTAL-1 -> 0; otherwise it holds.
REQ-021 On edges with PixEn=0, Hcounter, Vcounter, Hsync, Vsync and DispEn SHALL hold.
REQ-022 Hsync, Vsync and DispEn SHALL be decoded from the next counter values and registered with them: zero-cycle skew relative to the counter outputs.
REQ-023 Hsync asserted iff H_ACTIVE+H_FP <= Hcounter <= H_ACTIVE+H_FP+H_SYNC-1.
REQ-024 Vsync asserted iff V_ACTIVE+V_FP <= Vcounter <= V_ACTIVE+V_FP+V_SYNC-1, for every Hcounter on those lines.
REQ-025 DispEn = (Hcounter < H_ACTIVE) AND (Vcounter < V_ACTIVE).
REQ-026 LineStart SHALL be 1 for exactly one PixClk cycle after the enabled edge that loads Hcounter=0, and 0 on the next edge regardless of PixEn.
REQ-027 FrameStart SHALL follow the same rule for the edge that loads (0,0); LineStart SHALL also be 1 in that cycle.
REQ-028 No counter value outside 0..TOTAL-1 SHALL ever appear on the outputs.

Reset
REQ-029 While Locked=0, asynchronously: Hcounter=H_TOTAL-1, Vcounter=V_TOTAL-1, Hsync=~HS_POL, Vsync=~VS_POL, DispEn=0, LineStart=0, FrameStart=0.
REQ-030 The first enabled edge after Locked rises SHALL load (0,0) with DispEn=1, LineStart=1, FrameStart=1; no pixel of the first frame is lost.
REQ-031 Locked falling mid-frame SHALL immediately force the REQ-029 values, cancelling any pending pulse.

Verification
REQ-032 Defaults, PixEn=1, release reset -> cycle 1: H=0, V=0, FrameStart=1; FrameStart recurs every 420000 cycles; LineStart every 800.
REQ-033 Defaults, line 0 -> DispEn high at H=0..639, low at H=640..799; Hsync=0 exactly at H=656..751.
REQ-034 Defaults -> Vsync=0 for all 1600 cycles of lines 490..491, high elsewhere; V wraps 524 -> 0 together with H wrapping 799 -> 0.
REQ-035 PixEn toggling 1,0,1,0 -> counters advance every second cycle; LineStart/FrameStart still one PixClk cycle wide.
REQ-036 HS_POL=1, VS_POL=1, H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V totals 3/1/1/1 -> H period 8, Hsync=1 at H=5..6, frame period 48 cycles.
REQ-037 Assert Locked=0 at H=300,V=200, without a PixClk edge -> outputs match REQ-029 immediately; release -> next enabled edge gives (0,0), FrameStart=1.
